multi_cycle_controller: RTL and testbench

Sequencing FSM for the multi-cycle MIPS core. It steps each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath select, write strobe and ALU control word. It sits beside the shared ALU, register file, IR/MDR/A/B/ALUOut registers and the unified instruction/data memory. The memory port uses a ready handshake, so multi-cycle accesses stall the FSM.

---
 rtl/mips_ctrl_pkg.sv | 94 +++++++++
 rtl/alu_op_decode.sv | 86 ++++++++
 rtl/multi_cycle_controller.sv | 203 ++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
// Contents: FSM state enum, ALU control codes, opcode/funct constants,
// datapath select encodings and the ALU-decode class enum used between the
// sequencer and alu_op_decode.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EX_R,
        EX_I,
        EX_SHIFT,
        MEM_ADDR,
        MEM_RD,
        MEM_WR,
        WB_MEM,
        WB_ALU,
        BRANCH,
        JUMP
    } state_t;

    // Which family of ALU decode applies in the current state.
    typedef enum logic [2:0] {
        ClsNone,     // default: ADD, zero-extend
        ClsAddSext,  // address/branch-target add with sign-extended immediate
        ClsRtype,    // decode from Funct
        ClsShift,    // shift decode from Funct
        ClsImm,      // decode from OpCode
        ClsSub       // branch compare
    } alu_class_t;

    // ALU operation codes
    localparam logic [4:0] AluAdd  = 5'd0;
    localparam logic [4:0] AluSub  = 5'd1;
    localparam logic [4:0] AluAnd  = 5'd2;
    localparam logic [4:0] AluOr   = 5'd3;
    localparam logic [4:0] AluXor  = 5'd4;
    localparam logic [4:0] AluNor  = 5'd5;
    localparam logic [4:0] AluSl   = 5'd6;
    localparam logic [4:0] AluSr   = 5'd7;
    localparam logic [4:0] AluComp = 5'd8;

    // Opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpSltiu = 6'h0B;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSra  = 6'h03;
    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;
    localparam logic [5:0] FnSltu = 6'h2B;

    // Datapath select encodings
    localparam logic [1:0] RegDstRt    = 2'd0;
    localparam logic [1:0] RegDstRd    = 2'd1;
    localparam logic [1:0] RegDstRa    = 2'd2;
    localparam logic [1:0] MemtoRegAlu = 2'd0;
    localparam logic [1:0] MemtoRegMdr = 2'd1;
    localparam logic [1:0] MemtoRegPc  = 2'd2;
    localparam logic [1:0] SrcAPc      = 2'd0;
    localparam logic [1:0] SrcAReg    = 2'd1;
    localparam logic [1:0] SrcAShamt   = 2'd2;
    localparam logic [1:0] SrcBReg     = 2'd0;
    localparam logic [1:0] SrcBFour    = 2'd1;
    localparam logic [1:0] SrcBImm     = 2'd2;
    localparam logic [1:0] SrcBImmSh2  = 2'd3;
    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;
    localparam logic [1:0] PcSrcReg    = 2'd3;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control decode.
// Ports:
//   alu_class (in)  - decode family selected by the sequencer state
//   op_code   (in)  - IR[31:26]
//   funct     (in)  - IR[5:0]
//   alu_ctrl  (out) - ALU operation code
//   sign      (out) - signed compare / arithmetic shift
//   ext_op    (out) - 1 = sign-extend immediate
//   lui_op    (out) - select imm<<16 path
module alu_op_decode
    import mips_ctrl_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [5:0]  op_code,
    input  logic [5:0]  funct,
    output logic [4:0]  alu_ctrl,
    output logic        sign,
    output logic        ext_op,
    output logic        lui_op
);

    always_comb begin
        alu_ctrl = AluAdd;
        sign     = 1'b0;
        ext_op   = 1'b0;
        lui_op   = 1'b0;
        case (alu_class)
            ClsAddSext: ext_op = 1'b1;
            ClsSub:     alu_ctrl = AluSub;
            ClsRtype: begin
                case (funct)
                    FnSub, FnSubu: alu_ctrl = AluSub;
                    FnAnd:         alu_ctrl = AluAnd;
                    FnOr:          alu_ctrl = AluOr;
                    FnXor:         alu_ctrl = AluXor;
                    FnNor:         alu_ctrl = AluNor;
                    FnSlt: begin
                        alu_ctrl = AluComp;
                        sign     = 1'b1;
                    end
                    FnSltu:        alu_ctrl = AluComp;
                    default:       alu_ctrl = AluAdd;
                endcase
            end
            ClsShift: begin
                case (funct)
                    FnSll:   alu_ctrl = AluSl;
                    FnSrl:   alu_ctrl = AluSr;
                    FnSra: begin
                        alu_ctrl = AluSr;
                        sign     = 1'b1;
                    end
                    default: alu_ctrl = AluSl;
                endcase
            end
            ClsImm: begin
                ext_op = 1'b1;
                case (op_code)
                    OpSlti: begin
                        alu_ctrl = AluComp;
                        sign     = 1'b1;
                    end
                    OpSltiu: alu_ctrl = AluComp;
                    // Logical immediates are zero-extended.
                    OpAndi: begin
                        alu_ctrl = AluAnd;
                        ext_op   = 1'b0;
                    end
                    OpOri: begin
                        alu_ctrl = AluOr;
                        ext_op   = 1'b0;
                    end
                    OpXori: begin
                        alu_ctrl = AluXor;
                        ext_op   = 1'b0;
                    end
                    // Datapath forces A to 0, so ADD passes imm<<16 through.
                    OpLui:   lui_op = 1'b1;
                    default: alu_ctrl = AluAdd;
                endcase
            end
            default: alu_ctrl = AluAdd;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Sequencing FSM for the multi-cycle MIPS core.
// Steps each instruction through fetch/decode/execute/memory/write-back and
// drives all datapath selects, write strobes and the ALU control word.
// Ports:
//   clk, reset_n (sync, active-low)
//   OpCode, Funct, Zero, mem_ready                       - inputs
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
//   IRWrite, RegWrite                                    - strobes/selects
//   RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource         - 2-bit selects
//   ExtOp, LuiOp, ALUCtrl, Sign                          - ALU control
//   instr_done, illegal                                  - status pulses
// Outputs are combinational in state/OpCode/Funct/mem_ready; strobes and
// pulses are additionally gated by reset_n so reset takes effect at once.
module multi_cycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic        ExtOp,
    output logic        LuiOp,
    output logic [4:0]  ALUCtrl,
    output logic        Sign,
    output logic        instr_done,
    output logic        illegal
);

    state_t     state;
    state_t     dispatch;
    logic       legal;
    alu_class_t alu_class;

    logic pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write;
    logic done, illegal_raw;

    // Zero is consumed by the datapath's PCWriteCond qualification.
    logic unused_zero;
    assign unused_zero = Zero;

    // Decode dispatch from the freshly loaded IR.
    always_comb begin
        dispatch = FETCH;
        legal    = 1'b1;
        case (OpCode)
            OpLw, OpSw: dispatch = MEM_ADDR;
            OpRtype: begin
                case (Funct)
                    FnSll, FnSrl, FnSra: dispatch = EX_SHIFT;
                    FnJr:                dispatch = JUMP;
                    FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr, FnXor, FnNor,
                    FnSlt, FnSltu:       dispatch = EX_R;
                    default:             legal    = 1'b0;
                endcase
            end
            OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui:
                dispatch = EX_I;
            OpBeq:      dispatch = BRANCH;
            OpJ, OpJal: dispatch = JUMP;
            default:    legal    = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= RESET_STATE;
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE:   state <= dispatch;
                EX_R:     state <= WB_ALU;
                EX_I:     state <= WB_ALU;
                EX_SHIFT: state <= WB_ALU;
                MEM_ADDR: state <= (OpCode == OpLw) ? MEM_RD : MEM_WR;
                MEM_RD:   if (mem_ready) state <= WB_MEM;
                MEM_WR:   if (mem_ready) state <= FETCH;
                default:  state <= FETCH;  // WB_*, BRANCH, JUMP, unused codes
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        done          = 1'b0;
        illegal_raw   = 1'b0;
        IorD          = 1'b0;
        RegDst        = RegDstRt;
        MemtoReg      = MemtoRegAlu;
        ALUSrcA       = SrcAPc;
        ALUSrcB       = SrcBReg;
        PCSource      = PcSrcAlu;
        alu_class     = ClsNone;
        case (state)
            FETCH: begin
                mem_read = 1'b1;
                ALUSrcB  = SrcBFour;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            DECODE: begin
                ALUSrcB     = SrcBImmSh2;
                alu_class   = ClsAddSext;
                illegal_raw = ~legal;
            end
            EX_R: begin
                ALUSrcA   = SrcAReg;
                alu_class = ClsRtype;
            end
            EX_SHIFT: begin
                ALUSrcA   = SrcAShamt;
                alu_class = ClsShift;
            end
            EX_I: begin
                ALUSrcA   = SrcAReg;
                ALUSrcB   = SrcBImm;
                alu_class = ClsImm;
            end
            WB_ALU: begin
                reg_write = 1'b1;
                RegDst    = (OpCode == OpRtype) ? RegDstRd : RegDstRt;
                done      = 1'b1;
            end
            MEM_ADDR: begin
                ALUSrcA   = SrcAReg;
                ALUSrcB   = SrcBImm;
                alu_class = ClsAddSext;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                IorD     = 1'b1;
            end
            WB_MEM: begin
                reg_write = 1'b1;
                MemtoReg  = MemtoRegMdr;
                done      = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                IorD      = 1'b1;
                done      = mem_ready;
            end
            BRANCH: begin
                ALUSrcA       = SrcAReg;
                alu_class     = ClsSub;
                pc_write_cond = 1'b1;
                PCSource      = PcSrcAluOut;
                done          = 1'b1;
            end
            JUMP: begin
                pc_write = 1'b1;
                done     = 1'b1;
                PCSource = (OpCode == OpRtype && Funct == FnJr) ? PcSrcReg : PcSrcJump;
                if (OpCode == OpJal) begin
                    reg_write = 1'b1;
                    RegDst    = RegDstRa;
                    MemtoReg  = MemtoRegPc;
                end
            end
            default: ;
        endcase
    end

    alu_op_decode u_alu_op_decode (
        .alu_class (alu_class),
        .op_code   (OpCode),
        .funct     (Funct),
        .alu_ctrl  (ALUCtrl),
        .sign      (Sign),
        .ext_op    (ExtOp),
        .lui_op    (LuiOp)
    );

    assign PCWrite     = reset_n & pc_write;
    assign PCWriteCond = reset_n & pc_write_cond;
    assign MemRead     = reset_n & mem_read;
    assign MemWrite    = reset_n & mem_write;
    assign IRWrite     = reset_n & ir_write;
    assign RegWrite    = reset_n & reg_write;
    assign instr_done  = reset_n & done;
    assign illegal     = reset_n & illegal_raw;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: directed scenarios plus a
// randomized instruction stream, each checked cycle by cycle against an
// instruction-level timeline model.
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] OpCode, Funct;
    logic       Zero, mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic       ExtOp, LuiOp, Sign, instr_done, illegal;
    logic [4:0] ALUCtrl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_cycle_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .Zero        (Zero),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .ExtOp       (ExtOp),
        .LuiOp       (LuiOp),
        .ALUCtrl     (ALUCtrl),
        .Sign        (Sign),
        .instr_done  (instr_done),
        .illegal     (illegal)
    );

    typedef enum int {KindR, KindShift, KindJr, KindImm, KindLw, KindSw, KindBeq,
                      KindJ, KindJal, KindIll} kind_t;

    // Select word: {RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUCtrl, Sign, ExtOp, LuiOp}
    localparam logic [17:0] MRd  = 18'h30000;
    localparam logic [17:0] MMr  = 18'h0C000;
    localparam logic [17:0] MSa  = 18'h03000;
    localparam logic [17:0] MSb  = 18'h00C00;
    localparam logic [17:0] MPs  = 18'h00300;
    localparam logic [17:0] MAlu = 18'h000F8;
    localparam logic [17:0] MSg  = 18'h00004;
    localparam logic [17:0] MEx  = 18'h00002;
    localparam logic [17:0] MLu  = 18'h00001;

    function automatic logic [17:0] sel(int rd, int mr, int sa, int sb, int ps, int alu,
                                        int sg, int ex, int lu);
        return {2'(rd), 2'(mr), 2'(sa), 2'(sb), 2'(ps), 5'(alu), 1'(sg), 1'(ex), 1'(lu)};
    endfunction

    function automatic kind_t classify(logic [5:0] op, logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) return KindShift;
            if (fn == 6'h08) return KindJr;
            if ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2A || fn == 6'h2B) return KindR;
            return KindIll;
        end
        if (op == 6'h02) return KindJ;
        if (op == 6'h03) return KindJal;
        if (op == 6'h04) return KindBeq;
        if (op >= 6'h08 && op <= 6'h0F) return KindImm;
        if (op == 6'h23) return KindLw;
        if (op == 6'h2B) return KindSw;
        return KindIll;
    endfunction

    // Expected execute-cycle selects for ALU-type instructions.
    function automatic logic [17:0] exec_sel(kind_t k, logic [5:0] op, logic [5:0] fn);
        int idx;
        if (k == KindR) begin
            idx = int'(fn) - 32;
            if (fn == 6'h2A) return sel(0, 0, 1, 0, 0, 8, 1, 0, 0);
            if (fn == 6'h2B) return sel(0, 0, 1, 0, 0, 8, 0, 0, 0);
            // add,addu,sub,subu,and,or,xor,nor -> 0,0,1,1,2,3,4,5
            return sel(0, 0, 1, 0, 0, (idx < 2) ? 0 : (idx < 4) ? 1 : idx - 2, 0, 0, 0);
        end
        if (k == KindShift)
            return sel(0, 0, 2, 0, 0, (fn == 6'h00) ? 6 : 7, (fn == 6'h03) ? 1 : 0, 0, 0);
        idx = int'(op);
        if (idx == 8 || idx == 9) return sel(0, 0, 1, 2, 0, 0, 0, 1, 0);
        if (idx == 10) return sel(0, 0, 1, 2, 0, 8, 1, 1, 0);
        if (idx == 11) return sel(0, 0, 1, 2, 0, 8, 0, 1, 0);
        if (idx == 15) return sel(0, 0, 1, 2, 0, 0, 0, 1, 1);
        return sel(0, 0, 1, 2, 0, idx - 10, 0, 0, 0);  // andi/ori/xori
    endfunction

    // Runs one instruction with fs fetch-stall and ms memory-stall cycles.
    // Entry/exit: just after a rising edge, DUT expected in its fetch state.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fs,
                             input int ms);
        kind_t k = classify(op, fn);
        int last, mstart, mend;
        logic writes, in_fetch, in_mem, jumps;
        logic [8:0] exp_st, act_st;
        logic [17:0] exp_sel, mask, act_sel;
        if (k != KindLw && k != KindSw) ms = 0;
        mstart = fs + 3;
        mend   = fs + 3 + ms;
        case (k)
            KindLw:                        last = fs + ms + 4;
            KindSw:                        last = fs + ms + 3;
            KindR, KindShift, KindImm:     last = fs + 3;
            KindIll:                       last = fs + 1;
            default:                       last = fs + 2;
        endcase
        writes = (k == KindR || k == KindShift || k == KindImm || k == KindLw || k == KindJal);
        jumps  = (k == KindJ || k == KindJal || k == KindJr);
        for (int t = 0; t <= last; t++) begin
            in_fetch = (t <= fs);
            in_mem   = (k == KindLw || k == KindSw) && t >= mstart && t <= mend;
            if (in_fetch) begin
                OpCode = 6'($urandom);
                Funct  = 6'($urandom);
            end else begin
                OpCode = op;
                Funct  = fn;
            end
            Zero = 1'($urandom);
            if (in_fetch)    mem_ready = (t == fs);
            else if (in_mem) mem_ready = (t - mstart) >= ms;
            else             mem_ready = 1'($urandom);
            @(negedge clk);
            exp_st = {(t == fs) || (t == last && jumps),
                      (k == KindBeq && t == last),
                      in_mem,
                      in_fetch || (k == KindLw && in_mem),
                      (k == KindSw && in_mem),
                      (t == fs),
                      (t == last && writes),
                      (t == last && k != KindIll),
                      (t == last && k == KindIll)};
            act_st = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                      instr_done, illegal};
            checks++;
            if (act_st !== exp_st) begin
                errors++;
                $display("FAIL strobes t=%0d op=%02h fn=%02h got=%09b want=%09b",
                         t, op, fn, act_st, exp_st);
            end
            exp_sel = '0;
            mask    = '0;
            if (in_fetch) begin
                exp_sel = sel(0, 0, 0, 1, 0, 0, 0, 0, 0);
                mask    = MSa | MSb | MPs | MAlu | MSg;
            end else if (t == fs + 1) begin
                exp_sel = sel(0, 0, 0, 3, 0, 0, 0, 1, 0);
                mask    = MSa | MSb | MAlu | MEx;
            end else if (t == fs + 2) begin
                case (k)
                    KindR, KindShift, KindImm: begin
                        exp_sel = exec_sel(k, op, fn);
                        mask    = MSa | MSb | MAlu | MSg | MEx | MLu;
                    end
                    KindLw, KindSw: begin
                        exp_sel = sel(0, 0, 1, 2, 0, 0, 0, 1, 0);
                        mask    = MSa | MSb | MAlu | MEx;
                    end
                    KindBeq: begin
                        exp_sel = sel(0, 0, 1, 0, 1, 1, 0, 0, 0);
                        mask    = MSa | MSb | MAlu | MPs;
                    end
                    KindJ: begin
                        exp_sel = sel(0, 0, 0, 0, 2, 0, 0, 0, 0);
                        mask    = MPs;
                    end
                    KindJr: begin
                        exp_sel = sel(0, 0, 0, 0, 3, 0, 0, 0, 0);
                        mask    = MPs;
                    end
                    KindJal: begin
                        exp_sel = sel(2, 2, 0, 0, 2, 0, 0, 0, 0);
                        mask    = MRd | MMr | MPs;
                    end
                    default: ;
                endcase
            end else if (t == last && writes) begin
                if (k == KindLw)    exp_sel = sel(0, 1, 0, 0, 0, 0, 0, 0, 0);
                else if (k == KindImm) exp_sel = sel(0, 0, 0, 0, 0, 0, 0, 0, 0);
                else                exp_sel = sel(1, 0, 0, 0, 0, 0, 0, 0, 0);
                mask = MRd | MMr;
            end
            if (mask != '0) begin
                act_sel = {RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUCtrl, Sign,
                           ExtOp, LuiOp};
                checks++;
                if ((act_sel & mask) !== (exp_sel & mask)) begin
                    errors++;
                    $display("FAIL selects t=%0d op=%02h fn=%02h got=%05h want=%05h mask=%05h",
                             t, op, fn, act_sel & mask, exp_sel & mask, mask);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        Zero      = 1'b0;
        OpCode    = 6'h23;
        Funct     = 6'h20;
        repeat (2) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            // IorD is a select, not a strobe, so it is excluded.
            if (({PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, instr_done,
                  illegal}) !== 8'h00) begin
                errors++;
                $display("FAIL reset_strobes got=%08b want=00000000",
                         {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite,
                          instr_done, illegal});
            end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_add();
        run_instr(6'h00, 6'h20, 0, 0);
    endtask

    task automatic test_lw_stall();
        run_instr(6'h23, 6'h00, 0, 3);
        run_instr(6'h2B, 6'h11, 2, 2);
    endtask

    task automatic test_shift_compare();
        run_instr(6'h00, 6'h03, 0, 0);  // sra
        run_instr(6'h00, 6'h2B, 1, 0);  // sltu
        run_instr(6'h0F, 6'h00, 0, 0);  // lui
        run_instr(6'h0D, 6'h00, 0, 0);  // ori
    endtask

    task automatic test_branch_jump();
        run_instr(6'h04, 6'h15, 0, 0);  // beq
        run_instr(6'h03, 6'h3F, 0, 0);  // jal
        run_instr(6'h00, 6'h08, 1, 0);  // jr
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 6'h00, 0, 0);
        run_instr(6'h00, 6'h01, 0, 0);
        run_instr(6'h00, 6'h21, 0, 0);  // legal follow-up
    endtask

    task automatic test_reset_mid();
        // sw: FETCH, DECODE, MEM_ADDR, then MEM_WR stalled.
        OpCode    = 6'h2B;
        Funct     = 6'h00;
        mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_memwrite_before got=%b want=1", MemWrite);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({MemWrite, RegWrite, instr_done, PCWrite} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_strobes got=%04b want=0000",
                     {MemWrite, RegWrite, instr_done, PCWrite});
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_instr(6'h00, 6'h2A, 1, 0);  // starts from fetch if reset took effect
    endtask

    task automatic test_random();
        logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03,
                                 6'h08, 6'h0A, 6'h0C, 6'h0E, 6'h0F, 6'h00};
        logic [5:0] fns [14] = '{6'h22, 6'h27, 6'h02, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08};
        logic [5:0] op, fn;
        int pick;
        for (int i = 0; i < 200; i++) begin
            pick = int'($urandom_range(0, 17));
            if (pick < 14) begin
                op = ops[pick];
                fn = (op == 6'h00) ? fns[pick] : 6'($urandom);
            end else if (pick < 16) begin
                op = 6'h00;
                fn = 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            run_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_lw_stall();
        test_shift_compare();
        test_branch_jump();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
